stack_port_ctrl: RTL and testbench
==================================

# stack_port_ctrl

Client-side sequencer for the stack controller. It accepts write transfers and read requests from the datapath over valid/ready handshakes, then drives the controller's push/pop strobes while honouring its full/empty flags. It also drives the stack storage memory's write port and its synchronous read port, and returns popped data over a valid/ready handshake. It sits between the datapath and the stack controller plus storage pair; the controller owns the pointers, and this block owns sequencing and data movement.

## Interface
- DATA_WIDTH, 8, width of stack entries
- ADDR_WIDTH, 4, width of stack addresses; must match the controller
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  producer has a word to push
- wr_data  in  DATA_WIDTH  word to push
- wr_ready  out  1  push accepted this cycle
- rd_req_valid  in  1  consumer requests a pop
- rd_req_ready  out  1  pop request accepted this cycle
- rd_data  out  DATA_WIDTH  popped word, held while rd_data_valid=1
- rd_data_valid  out  1  rd_data is valid
- rd_data_ready  in  1  consumer takes rd_data
- push  out  1  push strobe to the controller
- pop  out  1  pop strobe to the controller
- full  in  1  controller full flag (registered in the controller)
- empty  in  1  controller empty flag (registered in the controller)
- w_addr  in  ADDR_WIDTH  controller write address
- r_addr  in  ADDR_WIDTH  controller read address
- mem_we  out  1  storage write enable
- mem_waddr  out  ADDR_WIDTH  storage write address, equal to w_addr
- mem_wdata  out  DATA_WIDTH  storage write data, equal to wr_data
- mem_raddr  out  ADDR_WIDTH  storage read address
- mem_rdata  in  DATA_WIDTH  storage read data, valid one cycle after mem_raddr is presented
- busy  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: push requests are eligible.
  - POP_RD: memory read cycle.
  - POP_OUT: rd_data is held until it is consumed.
- Eligibility in IDLE:
  - Push is eligible when wr_valid=1 and full=0.
  - Pop is eligible when rd_req_valid=1 and empty=0.
- Arbitration in IDLE when both are eligible: round-robin on the 1-bit register last_pop.
  - last_pop=0 grants pop.
  - last_pop=1 grants push.
  - last_pop updates only on a grant. Its reset value is 1, so push wins the first tie.
- Push grant (IDLE, Mealy, same cycle): push=mem_we=wr_ready=1, mem_waddr=w_addr, mem_wdata=wr_data. The FSM stays in IDLE.
- Pop grant (IDLE): pop=rd_req_ready=1. The register raddr_q captures r_addr. The FSM moves to POP_RD.
- mem_raddr=raddr_q in every state.
- POP_RD: rd_data captures mem_rdata. rd_data_valid becomes 1 on the next edge. The FSM moves to POP_OUT.
- POP_OUT: rd_data and rd_data_valid are held stable. When rd_data_valid=1 and rd_data_ready=1:
  - rd_data_valid clears on the next edge.
  - The FSM moves to IDLE.
- Outside IDLE:
  - push, pop, wr_ready and rd_req_ready are 0.
  - New requests wait; they are never dropped.
- push and pop are never asserted in the same cycle. The controller's simultaneous push+pop case is never exercised.
- A request that is not eligible (full or empty) stalls with its ready low indefinitely. No error is raised.
- wr_data and rd_req_valid must be held stable by the source until ready.

## Timing
- Reset (synchronous):
  - Registered values after the edge with reset=1: state=IDLE, rd_data=0, rd_data_valid=0, raddr_q=0, last_pop=1, busy=0.
  - Combinational strobes (push, pop, mem_we, wr_ready, rd_req_ready) are forced to 0 during any cycle in which reset=1.
- Push latency is 0 cycles; acceptance is combinational. Back-to-back pushes are possible, one per cycle.
- The controller's full flag updates one cycle after push. A push in the cycle where full becomes 1 is therefore already gated by the current flag value.
- Pop: request accepted at cycle T; rd_data_valid=1 from T+2. With rd_data_ready tied high, the FSM is back in IDLE at T+3, giving a pop throughput of 1 per 3 cycles.
- Reset mid-pop (in POP_RD or POP_OUT): return to IDLE and discard data. The controller, which shares the reset, also returns to empty.

## Test plan
- Reset: hold reset=1 for 2 cycles with wr_valid=1 and rd_req_valid=1 -> all outputs 0, busy=0, no push/pop pulse.
- Fill: 16 consecutive pushes of 8'h10..8'h1F with wr_valid held high -> one push pulse per cycle, mem_waddr equals w_addr each cycle. When full=1, wr_ready=0 and push stays 0 until a pop occurs.
- Pop data path: empty=0, r_addr=4'h3, mem[3]=8'hA5, pop request at T -> pop=1 at T, mem_raddr=3 from T+1, rd_data=8'hA5 with rd_data_valid=1 at T+2.
- Backpressure: rd_data_ready=0 for 5 cycles -> rd_data/rd_data_valid stable, busy=1, a concurrent wr_valid=1 gets no wr_ready. Raise ready -> IDLE next cycle, then the push is granted.
- Arbitration: both eligible for 4 consecutive grant opportunities after reset -> grant order push, pop, push, pop; push and pop never high together.
- Underflow/reset abort: rd_req_valid=1 with empty=1 -> no pop for 10 cycles. Then reset asserted during POP_OUT -> rd_data_valid=0 and state=IDLE after the edge.

Source files
------------

// File: rtl/stack_port_ctrl_if.sv
// Datapath-side handshakes of the stack port sequencer: push channel, pop request
// channel and popped-data return channel.
interface stack_port_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic                  rd_data_ready;

  modport master (
    output wr_valid, wr_data, rd_req_valid, rd_data_ready,
    input  wr_ready, rd_req_ready, rd_data, rd_data_valid
  );

  modport slave (
    input  wr_valid, wr_data, rd_req_valid, rd_data_ready,
    output wr_ready, rd_req_ready, rd_data, rd_data_valid
  );
endinterface

// File: rtl/stack_port_ctrl.sv
// Client-side sequencer for the stack controller: arbitrates pushes and pops, drives the
// storage write/read ports and returns popped words over a valid/ready handshake.
module stack_port_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  stack_port_ctrl_if.slave      dp,
  output logic                  push,
  output logic                  pop,
  input  logic                  full,
  input  logic                  empty,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StPopRd, StPopOut} state_e;

  state_e                state_q, state_d;
  logic                  last_pop_q, last_pop_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  push_ok, pop_ok;
  logic                  grant_push, grant_pop;

  assign push_ok = dp.wr_valid & ~full;
  assign pop_ok  = dp.rd_req_valid & ~empty;

  always_comb begin
    state_d    = state_q;
    last_pop_d = last_pop_q;
    raddr_d    = raddr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    grant_push = 1'b0;
    grant_pop  = 1'b0;
    case (state_q)
      StIdle: begin
        // Round-robin on a tie: last_pop_q=0 hands the grant to pop.
        grant_pop  = ~reset & pop_ok & (~push_ok | ~last_pop_q);
        grant_push = ~reset & push_ok & ~grant_pop;
        if (grant_pop) begin
          raddr_d    = r_addr;
          last_pop_d = 1'b1;
          state_d    = StPopRd;
        end else if (grant_push) begin
          last_pop_d = 1'b0;
        end
      end
      StPopRd: begin
        rd_data_d  = mem_rdata;
        rd_valid_d = 1'b1;
        state_d    = StPopOut;
      end
      StPopOut: begin
        if (rd_valid_q && dp.rd_data_ready) begin
          rd_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      last_pop_q <= 1'b1;
      raddr_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_pop_q <= last_pop_d;
      raddr_q    <= raddr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign push             = grant_push;
  assign mem_we           = grant_push;
  assign dp.wr_ready      = grant_push;
  assign pop              = grant_pop;
  assign dp.rd_req_ready  = grant_pop;
  assign mem_waddr        = w_addr;
  assign mem_wdata        = dp.wr_data;
  assign mem_raddr        = raddr_q;
  assign dp.rd_data       = rd_data_q;
  assign dp.rd_data_valid = rd_valid_q;
  assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_stack_port_ctrl.sv
// Directed bench for stack_port_ctrl: flags and addresses are driven as vectors, storage
// is a small array model.
module tb_stack_port_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       push, pop, full, empty;
  logic [3:0] w_addr, r_addr;
  logic       mem_we;
  logic [3:0] mem_waddr, mem_raddr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       busy;

  logic [7:0] mem [16];
  logic       tb_we;
  logic [3:0] tb_waddr;
  logic [7:0] tb_wdata;

  int n_checks = 0;
  int n_errors = 0;

  stack_port_ctrl_if #(.DATA_WIDTH(8)) dp_if ();

  stack_port_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .dp       (dp_if),
    .push     (push),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .w_addr   (w_addr),
    .r_addr   (r_addr),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    else if (tb_we) mem[tb_waddr] <= tb_wdata;
  end

  assign mem_rdata = mem[mem_raddr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [3:0] a, input logic [7:0] d);
    tb_waddr = a;
    tb_wdata = d;
    tb_we    = 1'b1;
    step();
    tb_we    = 1'b0;
  endtask

  initial begin
    reset                = 1'b1;
    dp_if.wr_valid       = 1'b1;
    dp_if.wr_data        = 8'h10;
    dp_if.rd_req_valid   = 1'b1;
    dp_if.rd_data_ready  = 1'b1;
    full                 = 1'b0;
    empty                = 1'b0;
    w_addr               = 4'h0;
    r_addr               = 4'h0;
    tb_we                = 1'b0;
    tb_waddr             = 4'h0;
    tb_wdata             = 8'h00;

    // Reset held two cycles with both requests pending.
    poke(4'h5, 8'h5C);
    step();
    #1;
    check_eq("rst_push", push, 1'b0);
    check_eq("rst_pop", pop, 1'b0);
    check_eq("rst_wr_ready", dp_if.wr_ready, 1'b0);
    check_eq("rst_rd_req_ready", dp_if.rd_req_ready, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rd_valid", dp_if.rd_data_valid, 1'b0);
    check_eq("rst_rd_data", dp_if.rd_data, 8'h00);
    check_eq("rst_mem_raddr", mem_raddr, 4'h0);

    // Arbitration: both eligible, expect push, pop, push, pop.
    step();
    reset = 1'b0; w_addr = 4'h7; r_addr = 4'h5; dp_if.wr_data = 8'h21;
    #1;
    check_eq("arb0_push", push, 1'b1);
    check_eq("arb0_pop", pop, 1'b0);
    step();
    dp_if.wr_data = 8'h22;
    #1;
    check_eq("arb1_pop", pop, 1'b1);
    check_eq("arb1_push", push, 1'b0);
    check_eq("arb1_rd_req_ready", dp_if.rd_req_ready, 1'b1);
    step(); #1;
    check_eq("arb_poprd_strobes", {push, pop, dp_if.wr_ready}, 3'b000);
    check_eq("arb_poprd_busy", busy, 1'b1);
    check_eq("arb_poprd_raddr", mem_raddr, 4'h5);
    step(); #1;
    check_eq("arb_popout_valid", dp_if.rd_data_valid, 1'b1);
    check_eq("arb_popout_data", dp_if.rd_data, 8'h5C);
    check_eq("arb_popout_push", push, 1'b0);
    step(); #1;
    check_eq("arb2_push", push, 1'b1);
    check_eq("arb2_pop", pop, 1'b0);
    check_eq("arb2_busy", busy, 1'b0);
    step(); #1;
    check_eq("arb3_pop", pop, 1'b1);
    check_eq("arb3_push", push, 1'b0);
    step();
    dp_if.rd_req_valid = 1'b0; dp_if.wr_valid = 1'b0;
    step();
    step(); #1;
    check_eq("arb_done_busy", busy, 1'b0);

    // Fill: 16 back-to-back pushes, then full stalls the producer.
    reset = 1'b1;
    step();
    reset = 1'b0; dp_if.wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w_addr = 4'(i);
      dp_if.wr_data = 8'(8'h10 + i);
      #1;
      check_eq($sformatf("fill%0d_push", i), push, 1'b1);
      check_eq($sformatf("fill%0d_waddr", i), mem_waddr, 32'(i));
      check_eq($sformatf("fill%0d_wdata", i), mem_wdata, 32'(8'h10 + i));
      step();
    end
    full = 1'b1; dp_if.wr_data = 8'h30;
    #1;
    check_eq("full_wr_ready", dp_if.wr_ready, 1'b0);
    check_eq("full_push", push, 1'b0);
    step(); #1;
    check_eq("full_hold_push", push, 1'b0);
    dp_if.rd_req_valid = 1'b1; r_addr = 4'hF;
    #1;
    check_eq("full_pop", pop, 1'b1);
    check_eq("full_pop_push", push, 1'b0);
    step();
    dp_if.rd_req_valid = 1'b0; full = 1'b0;
    #1;
    check_eq("full_poprd_push", push, 1'b0);
    check_eq("full_poprd_raddr", mem_raddr, 4'hF);
    step(); #1;
    check_eq("full_popout_valid", dp_if.rd_data_valid, 1'b1);
    check_eq("full_popout_data", dp_if.rd_data, 8'h1F);
    step(); #1;
    check_eq("refill_push", push, 1'b1);
    check_eq("refill_wdata", mem_wdata, 8'h30);
    step();
    dp_if.wr_valid = 1'b0;

    // Pop data path with 5+ cycles of backpressure and a waiting push.
    poke(4'h3, 8'hA5);
    dp_if.rd_req_valid = 1'b1; r_addr = 4'h3; dp_if.rd_data_ready = 1'b0;
    #1;
    check_eq("bp_pop", pop, 1'b1);
    step();
    dp_if.rd_req_valid = 1'b0; dp_if.wr_valid = 1'b1; dp_if.wr_data = 8'h77; w_addr = 4'h4;
    #1;
    check_eq("bp_raddr", mem_raddr, 4'h3);
    check_eq("bp_poprd_pop", pop, 1'b0);
    check_eq("bp_poprd_wr_ready", dp_if.wr_ready, 1'b0);
    check_eq("bp_poprd_valid", dp_if.rd_data_valid, 1'b0);
    step(); #1;
    check_eq("bp_valid", dp_if.rd_data_valid, 1'b1);
    check_eq("bp_data", dp_if.rd_data, 8'hA5);
    for (int k = 0; k < 5; k++) begin
      step(); #1;
      check_eq($sformatf("bp_hold%0d_valid", k), dp_if.rd_data_valid, 1'b1);
      check_eq($sformatf("bp_hold%0d_data", k), dp_if.rd_data, 8'hA5);
      check_eq($sformatf("bp_hold%0d_busy", k), busy, 1'b1);
      check_eq($sformatf("bp_hold%0d_wr_ready", k), dp_if.wr_ready, 1'b0);
    end
    step();
    dp_if.rd_data_ready = 1'b1;
    #1;
    check_eq("bp_release_valid", dp_if.rd_data_valid, 1'b1);
    check_eq("bp_release_wr_ready", dp_if.wr_ready, 1'b0);
    step(); #1;
    check_eq("bp_idle_busy", busy, 1'b0);
    check_eq("bp_idle_valid", dp_if.rd_data_valid, 1'b0);
    check_eq("bp_idle_push", push, 1'b1);
    check_eq("bp_idle_wr_ready", dp_if.wr_ready, 1'b1);
    check_eq("bp_idle_wdata", mem_wdata, 8'h77);
    step();
    dp_if.wr_valid = 1'b0;

    // Underflow stall, then reset while holding popped data.
    dp_if.rd_req_valid = 1'b1; empty = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check_eq($sformatf("empty%0d_pop", k), pop, 1'b0);
      check_eq($sformatf("empty%0d_rd_req_ready", k), dp_if.rd_req_ready, 1'b0);
      step();
    end
    check_eq("empty_busy", busy, 1'b0);
    empty = 1'b0; r_addr = 4'h3;
    #1;
    check_eq("abort_pop", pop, 1'b1);
    step();
    dp_if.rd_req_valid = 1'b0; dp_if.rd_data_ready = 1'b0;
    step(); #1;
    check_eq("abort_popout_valid", dp_if.rd_data_valid, 1'b1);
    check_eq("abort_popout_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("abort_rst_pop", pop, 1'b0);
    step();
    reset = 1'b0;
    #1;
    check_eq("abort_valid", dp_if.rd_data_valid, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_data", dp_if.rd_data, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
